// File: rtl/io_pkg.sv
// io_pkg: shared MMIO address map for the board I/O blocks.
`default_nettype none

package io_pkg;

  localparam logic [31:0] IO_OUT0_ADDR = 32'h0000_7000;
  localparam logic [31:0] IO_OUT1_ADDR = 32'h0000_7010;
  localparam logic [31:0] IO_OUT2_ADDR = 32'h0000_7020;
  localparam logic [31:0] IO_OUT3_ADDR = 32'h0000_7024;
  localparam logic [31:0] IO_IN_BASE   = 32'h0000_7800;

  localparam logic [3:0] IN_SW_OFF    = 4'h0;
  localparam logic [3:0] IN_BTN_OFF   = 4'h4;
  localparam logic [3:0] IN_PRESS_OFF = 4'h8;
  localparam logic [3:0] IN_REL_OFF   = 4'hC;

endpackage

`default_nettype wire

// File: rtl/debounce_cell.sv
// debounce_cell: two-flop synchroniser, glitch-rejecting debounce counter
// and edge strobes for one push-button.
`default_nettype none

module debounce_cell #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // Edge strobes are asserted in the cycle before the flip so the sticky
  // registers set on the same clock edge as the level change.
  assign flip    = (sync2 != stable) && (cnt == CNT_MAX);
  assign o_rise  = flip & sync2;
  assign o_fall  = flip & ~sync2;
  assign o_level = stable;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= (ACTIVE_LOW != 0) ? ~i_btn : i_btn;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/io_input_cond.sv
// io_input_cond: synchronised switches, debounced buttons and W1C sticky
// press/release registers behind a zero-wait-state MMIO read port.
`default_nettype none

module io_input_cond
  import io_pkg::*;
#(
  parameter int SW_W            = 32,
  parameter int N_BTN           = 4,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [SW_W-1:0]  i_io_sw,
  input  logic [N_BTN-1:0] i_io_btn,
  input  logic             i_sel,
  input  logic [3:0]       i_addr,
  input  logic             i_we,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  output logic             o_btn_evt
);

  logic [SW_W-1:0]  sw_s1;
  logic [SW_W-1:0]  sw_s2;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] rel;
  logic [N_BTN-1:0] clr_press;
  logic [N_BTN-1:0] clr_rel;
  logic [3:0]       reg_off;
  logic             wr_hit;
  logic             unused_bits;

  assign reg_off     = {i_addr[3:2], 2'b00};
  assign wr_hit      = i_sel & i_we;
  assign clr_press   = (wr_hit && reg_off == IN_PRESS_OFF) ? i_wdata[N_BTN-1:0] : '0;
  assign clr_rel     = (wr_hit && reg_off == IN_REL_OFF)   ? i_wdata[N_BTN-1:0] : '0;
  assign unused_bits = ^{i_addr[1:0], i_wdata};

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_cell #(
      .ACTIVE_LOW      (BTN_ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .clk     (clk),
      .rstn    (rstn),
      .i_btn   (i_io_btn[i]),
      .o_level (level[i]),
      .o_rise  (rise[i]),
      .o_fall  (fall[i])
    );
  end

  // Set is OR-ed in after the clear so a coincident event is never lost.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      press <= '0;
      rel   <= '0;
    end else begin
      sw_s1 <= i_io_sw;
      sw_s2 <= sw_s1;
      press <= (press & ~clr_press) | rise;
      rel   <= (rel & ~clr_rel) | fall;
    end
  end

  always_comb begin
    o_rdata = '0;
    if (i_sel) begin
      case (reg_off)
        IN_SW_OFF:    o_rdata[SW_W-1:0]  = sw_s2;
        IN_BTN_OFF:   o_rdata[N_BTN-1:0] = level;
        IN_PRESS_OFF: o_rdata[N_BTN-1:0] = press;
        IN_REL_OFF:   o_rdata[N_BTN-1:0] = rel;
        default:      o_rdata = '0;
      endcase
    end
  end

  assign o_btn_evt = (|press) | (|rel);

endmodule

`default_nettype wire

// File: tb/tb_io_input_cond.sv
// tb_io_input_cond: directed self-checking bench, DEBOUNCE_CYCLES=4, active-low buttons.
`default_nettype none

module tb_io_input_cond;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] io_sw;
  logic [3:0]  io_btn;
  logic        sel;
  logic [3:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        btn_evt;

  int checks   = 0;
  int failures = 0;

  io_input_cond #(
    .SW_W            (32),
    .N_BTN           (4),
    .BTN_ACTIVE_LOW  (1),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_io_sw   (io_sw),
    .i_io_btn  (io_btn),
    .i_sel     (sel),
    .i_addr    (addr),
    .i_we      (we),
    .i_wdata   (wdata),
    .o_rdata   (rdata),
    .o_btn_evt (btn_evt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    sel  = 1'b1;
    addr = a;
    we   = 1'b0;
    #1;
    d    = rdata;
    sel  = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    sel   = 1'b0;
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rstn   = 1'b0;
    io_btn = 4'hF;
    io_sw  = 32'hA5A5_A5A5;
    repeat (4) tick();
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_unsel_rdata: got %h want %h", rdata, 32'h0); end
    rd(4'h4, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_btn: got %h want %h", d, 32'h0); end
    rd(4'h8, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_press: got %h want %h", d, 32'h0); end
    checks++; if (btn_evt !== 1'b0) begin failures++; $display("FAIL reset_evt: got %b want 0", btn_evt); end
    rd(4'h0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_sw: got %h want %h", d, 32'h0); end
    rstn = 1'b1;
    tick();
    rd(4'h0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL sw_lat1: got %h want %h", d, 32'h0); end
    tick();
    rd(4'h0, d);
    checks++; if (d !== 32'hA5A5_A5A5) begin failures++; $display("FAIL sw_lat2: got %h want %h", d, 32'hA5A5_A5A5); end
    io_sw = 32'h0000_1234;
    tick();
    rd(4'h0, d);
    checks++; if (d !== 32'hA5A5_A5A5) begin failures++; $display("FAIL sw_chg1: got %h want %h", d, 32'hA5A5_A5A5); end
    tick();
    rd(4'h0, d);
    checks++; if (d !== 32'h0000_1234) begin failures++; $display("FAIL sw_chg2: got %h want %h", d, 32'h0000_1234); end
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    logic [31:0] p;
    for (int c = 0; c < 20; c++) begin
      io_btn = ((c / 2) % 2 == 0) ? 4'hE : 4'hF;
      tick();
      rd(4'h4, d);
      rd(4'h8, p);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL bounce_btn c=%0d: got %h want %h", c, d, 32'h0); end
      checks++; if (p !== 32'h0) begin failures++; $display("FAIL bounce_press c=%0d: got %h want %h", c, p, 32'h0); end
    end
    io_btn = 4'hF;
    repeat (8) tick();
    rd(4'h4, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL bounce_settle_btn: got %h want %h", d, 32'h0); end
    checks++; if (btn_evt !== 1'b0) begin failures++; $display("FAIL bounce_evt: got %b want 0", btn_evt); end
  endtask

  task automatic test_press();
    logic [31:0] d;
    logic [31:0] p;
    io_btn = 4'hE;
    for (int e = 1; e <= 5; e++) begin
      tick();
      rd(4'h4, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL press_early e=%0d: got %h want %h", e, d, 32'h0); end
    end
    checks++; if (btn_evt !== 1'b0) begin failures++; $display("FAIL press_evt_early: got %b want 0", btn_evt); end
    tick();
    rd(4'h4, d);
    rd(4'h8, p);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL press_btn: got %h want %h", d, 32'h1); end
    checks++; if (p !== 32'h1) begin failures++; $display("FAIL press_sticky: got %h want %h", p, 32'h1); end
    checks++; if (btn_evt !== 1'b1) begin failures++; $display("FAIL press_evt: got %b want 1", btn_evt); end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    io_btn = 4'hC;
    repeat (6) tick();
    rd(4'h8, d);
    checks++; if (d !== 32'h3) begin failures++; $display("FAIL w1c_pre: got %h want %h", d, 32'h3); end
    sel = 1'b1; we = 1'b1; addr = 4'h8; wdata = 32'h1;
    #1;
    checks++; if (rdata !== 32'h3) begin failures++; $display("FAIL w1c_read_same_cycle: got %h want %h", rdata, 32'h3); end
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0; wdata = '0;
    rd(4'h8, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL w1c_clear: got %h want %h", d, 32'h2); end
    wr(4'h8, 32'h0);
    rd(4'h8, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL w1c_zero: got %h want %h", d, 32'h2); end
    wr(4'h4, 32'hFFFF_FFFF);
    rd(4'h4, d);
    checks++; if (d !== 32'h3) begin failures++; $display("FAIL w1c_btn_ro: got %h want %h", d, 32'h3); end
    rd(4'h8, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL w1c_btn_wr_press: got %h want %h", d, 32'h2); end
    rd(4'h0, d);
    checks++; if (d !== 32'h0000_1234) begin failures++; $display("FAIL w1c_sw_ro: got %h want %h", d, 32'h0000_1234); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    io_btn = 4'hE;
    repeat (6) tick();
    rd(4'hC, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL rel_btn1: got %h want %h", d, 32'h2); end
    wr(4'h8, 32'h2);
    wr(4'hC, 32'h2);
    rd(4'h8, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL setwins_pre_press: got %h want %h", d, 32'h0); end
    checks++; if (btn_evt !== 1'b0) begin failures++; $display("FAIL setwins_pre_evt: got %b want 0", btn_evt); end
    io_btn = 4'hC;
    repeat (5) tick();
    rd(4'h4, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL setwins_pre_btn: got %h want %h", d, 32'h1); end
    wr(4'h8, 32'h2);
    rd(4'h8, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL setwins_press: got %h want %h", d, 32'h2); end
    rd(4'h4, d);
    checks++; if (d !== 32'h3) begin failures++; $display("FAIL setwins_btn: got %h want %h", d, 32'h3); end
  endtask

  task automatic test_release_reset();
    logic [31:0] d;
    logic [31:0] p;
    io_btn = 4'hD;
    repeat (5) tick();
    rd(4'hC, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rel_early: got %h want %h", d, 32'h0); end
    tick();
    rd(4'hC, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL rel_btn0: got %h want %h", d, 32'h1); end
    rd(4'h4, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL rel_level: got %h want %h", d, 32'h2); end
    io_btn = 4'h9;
    repeat (4) tick();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    rd(4'h4, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL midrst_btn: got %h want %h", d, 32'h0); end
    rd(4'h8, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL midrst_press: got %h want %h", d, 32'h0); end
    rd(4'hC, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL midrst_rel: got %h want %h", d, 32'h0); end
    checks++; if (btn_evt !== 1'b0) begin failures++; $display("FAIL midrst_evt: got %b want 0", btn_evt); end
    repeat (5) tick();
    rd(4'h8, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL midrst_restart: got %h want %h", d, 32'h0); end
    tick();
    rd(4'h4, d);
    rd(4'h8, p);
    checks++; if (d !== 32'h6) begin failures++; $display("FAIL postrst_btn: got %h want %h", d, 32'h6); end
    checks++; if (p !== 32'h6) begin failures++; $display("FAIL postrst_press: got %h want %h", p, 32'h6); end
  endtask

  initial begin
    rstn   = 1'b0;
    io_sw  = '0;
    io_btn = 4'hF;
    sel    = 1'b0;
    addr   = '0;
    we     = 1'b0;
    wdata  = '0;
    test_reset();
    test_bounce();
    test_press();
    test_w1c();
    test_set_wins();
    test_release_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/io_input_cond.md
# io_input_cond

Input-conditioning stage that sits directly upstream of the LSU's MMIO read path for the board switches and push-buttons. It synchronises `i_io_sw` and `i_io_btn` into `clk`, debounces the buttons, and captures press and release edges in sticky registers. Firmware reads these registers with single-cycle, combinational-read semantics and clears them with write-1-to-clear. Firmware therefore never samples raw, metastable or bouncing pins.

## Interface
Parameters:
- `SW_W`, 32: switch bus width.
- `N_BTN`, 4: number of buttons.
- `BTN_ACTIVE_LOW`, 1: when 1, buttons are inverted at the input so that logical 1 means pressed.
- `DEBOUNCE_CYCLES`, 500000: consecutive differing cycles required before the debounced level flips; legal range ≥ 2.

Ports:
- `clk`  in  1: clock.
- `rstn`  in  1: reset, synchronous, active-low.
- `i_io_sw`  in  SW_W: raw switches, asynchronous.
- `i_io_btn`  in  N_BTN: raw buttons, asynchronous.
- `i_sel`  in  1: LSU address decode hit for this block (0x7800–0x780F).
- `i_addr`  in  4: byte offset within the block; bits [1:0] are ignored.
- `i_we`  in  1: store strobe, qualified by `i_sel`.
- `i_wdata`  in  32: store data.
- `o_rdata`  out  32: read data, combinational from registered state.
- `o_btn_evt`  out  1: high while any press or release sticky bit is set.

## Operation
- **Register map** (unused bits read 0):
  - 0x0 `SW`: synchronised switch level. Read-only.
  - 0x4 `BTN`: debounced button level in [N_BTN-1:0]. Read-only.
  - 0x8 `PRESS`: sticky rising edges of the debounced level. W1C.
  - 0xC `REL`: sticky falling edges of the debounced level. W1C.
- Writes to 0x0 and 0x4 are ignored. When `i_sel` = 0, `o_rdata` = 0.
- **Synchroniser:** two flip-flops per bit for both switches and buttons. The button polarity inversion is applied before the first flip-flop.
- **Debounce, per button** (`stable`, counter `cnt` of width $clog2(DEBOUNCE_CYCLES)):
  - `sync2 == stable`: `cnt` ← 0.
  - `sync2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` ← `cnt`+1.
  - `sync2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable` ← `sync2`, `cnt` ← 0.
  - Any single-cycle return to the `stable` value restarts the count (glitch rejection).
- **Edge capture:**
  - On the edge where `stable` goes 0→1, `PRESS[i]` ← 1.
  - On the edge where `stable` goes 1→0, `REL[i]` ← 1.
- **W1C:** on `i_sel & i_we` to 0x8 or 0xC, each bit with `i_wdata[i]` = 1 is cleared.
- **Simultaneous set and clear** on the same bit in the same cycle: set wins, so the event is never lost.
- `o_btn_evt` = |PRESS | |REL.

## Timing
- All outputs reset to 0 in the cycle after `rstn` is sampled low:
  - sync flip-flops = 0, `stable` = 0, `cnt` = 0;
  - `PRESS` = 0, `REL` = 0;
  - `o_rdata` = 0 (unselected), `o_btn_evt` = 0.
- Reset asserted mid-count discards the count and any pending edge.
- **Switch latency:** a raw change held across edges k and k+1 is visible in `SW` after edge k+1 (2 cycles).
- **Button latency:** a raw change held from before edge k is visible in `BTN` and sets `PRESS`/`REL` after edge k+1+DEBOUNCE_CYCLES.
- **Read:** `o_rdata` is valid in the same cycle as `i_sel`/`i_addr`, with no wait states. This is required for the single-cycle core.
- **W1C timing:** the clear takes effect at the store's clock edge. A read in the same cycle returns the pre-clear value.
- **Counter width:** `cnt` never wraps, because it saturates at DEBOUNCE_CYCLES-1 and then resets to 0.

## Structure
- **Shared package `io_pkg`:**
  - base addresses `IO_IN_BASE` = 32'h7800 and the existing 0x7000/0x7010/0x7020/0x7024 output addresses;
  - offset constants `IN_SW_OFF`, `IN_BTN_OFF`, `IN_PRESS_OFF`, `IN_REL_OFF`.
- **Sub-module `debounce_cell`:** one button's sync pair, counter and `stable` bit, with outputs `o_level`, `o_rise`, `o_fall`. It is instantiated N_BTN times via generate.
- The top level holds the switch synchroniser, the sticky registers and the read mux.

## Test plan
All tests use `DEBOUNCE_CYCLES`=4 and `BTN_ACTIVE_LOW`=1.
1. **Reset:** hold `rstn`=0 for 4 cycles with `i_io_btn`=4'hF and `i_io_sw`=32'hA5A5A5A5 → read `BTN`=0, `PRESS`=0, `o_btn_evt`=0. `SW` reads 0xA5A5A5A5 two cycles after release.
2. **Clean press:** drive `i_io_btn`=4'hE (btn0 pressed) → `BTN`=1 exactly 6 edges later; `PRESS`=0x1 and `o_btn_evt`=1 on the same edge.
3. **Bounce:** btn0 toggles pressed/released every 2 cycles for 20 cycles, then stays released → `BTN` stays 0 and `PRESS` stays 0 throughout.
4. **W1C:** with `PRESS`=0x3, write 0x1 to 0x8 → `PRESS`=0x2. Writing 0x0 to 0x8 or 0xFFFFFFFF to 0x4 leaves all registers unchanged.
5. **Set-wins:** schedule the W1C of `PRESS[1]` on the same edge that btn1's debounced level rises → `PRESS[1]`=1 afterwards.
6. **Release and mid-count reset:**
   - release btn0 → `REL`=0x1 six edges later;
   - assert `rstn`=0 with `cnt`=2 on btn2 → after reset `BTN[2]`=0 and no `PRESS` bit is set.
